// File: rtl/id_ex_latch.sv
// ID/EX pipeline latch with load-use hazard detection and a bubble counter.
//
// Registers the decode-stage control bundles and datapath values for the EX
// stage. A one-cycle load-use hazard is detected combinationally from the
// instruction currently in EX and the source registers being decoded. When a
// hazard is seen, a bubble is inserted. A branch flush also inserts a bubble.
// A saturating counter records the number of bubbles.
//
// Optional build macro:
//   IDEX_FORWARD_EN - adds the rs_out register for an external forwarding
//                     unit. When the macro is undefined, rs_in drives only
//                     hazard detection.
module id_ex_latch (
  input  logic        clk,
  input  logic        rst_n,
  // Decode-stage control bundles.
  input  logic [3:0]  ex_in,       // {RegDst, ALUOp[1:0], ALUSrc}
  input  logic [2:0]  m_in,        // {Branch, MemRead, MemWrite}
  input  logic [1:0]  wb_in,       // {RegWrite, MemToReg}
  // Decode-stage datapath values.
  input  logic [31:0] npc_in,
  input  logic [31:0] rd1_in,
  input  logic [31:0] rd2_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  // Pipeline control.
  input  logic        flush,
  input  logic        hold,
  // EX-stage registered copies.
  output logic [3:0]  ex_out,
  output logic [2:0]  m_out,
  output logic [1:0]  wb_out,
  output logic [31:0] npc_out,
  output logic [31:0] rd1_out,
  output logic [31:0] rd2_out,
  output logic [31:0] imm_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  rd_out,
`ifdef IDEX_FORWARD_EN
  output logic [4:0]  rs_out,
`endif
  output logic        valid_out,
  output logic        stall_out,
  output logic [15:0] bubble_cnt
);

  // One action applies per clock edge. The list below is in priority order.
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } action_e;

  // Bit position of MemRead inside the M bundle.
  localparam int unsigned MEM_READ_BIT = 1;

  action_e     action;
  logic        rt_match;
  logic [15:0] bubble_cnt_inc;

  // Detect a load-use hazard and select this cycle's action.
  // NOTE: every signal that always_comb drives gets a default value first.
  // A path that does not assign a signal would infer a latch.
  always_comb begin
    rt_match  = 1'b0;
    stall_out = 1'b0;
    action    = ACT_LOAD;

    // The EX-stage load writes rt. This is a hazard if the instruction being
    // decoded reads rt through either of its source fields.
    rt_match  = (rt_out == rs_in) || (rt_out == rt_in);

    // An invalid slot is a bubble, and a bubble never raises a stall. This
    // limits a load-use stall to exactly one cycle. A flush removes the
    // dependent instruction, so a flush also suppresses the stall.
    stall_out = valid_out & m_out[MEM_READ_BIT] & rt_match & ~flush;

    if (!rst_n) begin
      action = ACT_RESET;
    end else if (flush) begin
      action = ACT_FLUSH;
    end else if (hold) begin
      action = ACT_HOLD;
    end else if (stall_out) begin
      action = ACT_BUBBLE;
    end else begin
      action = ACT_LOAD;
    end
  end

  // Compute the counter's next value. It holds at all-ones instead of
  // wrapping to zero.
  always_comb begin
    bubble_cnt_inc = bubble_cnt;
    if (bubble_cnt != 16'hFFFF) begin
      bubble_cnt_inc = bubble_cnt + 16'd1;
    end
  end

  // Control bundles and the valid flag. Both flush and hazard bubbles clear them.
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together at the clock edge, and simulation matches the synthesised
  // flops.
  always_ff @(posedge clk) begin
    unique case (action)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
        ex_out    <= '0;
        m_out     <= '0;
        wb_out    <= '0;
        valid_out <= 1'b0;
      end
      ACT_LOAD: begin
        ex_out    <= ex_in;
        m_out     <= m_in;
        wb_out    <= wb_in;
        valid_out <= 1'b1;
      end
      default: begin
        ex_out    <= ex_out;
        m_out     <= m_out;
        wb_out    <= wb_out;
        valid_out <= valid_out;
      end
    endcase
  end

  // Datapath registers. A bubble leaves them unchanged because its control
  // bundles are zero, so no later stage reads these values.
  always_ff @(posedge clk) begin
    unique case (action)
      ACT_RESET: begin
        npc_out <= '0;
        rd1_out <= '0;
        rd2_out <= '0;
        imm_out <= '0;
        rt_out  <= '0;
        rd_out  <= '0;
      end
      ACT_LOAD: begin
        npc_out <= npc_in;
        rd1_out <= rd1_in;
        rd2_out <= rd2_in;
        imm_out <= imm_in;
        rt_out  <= rt_in;
        rd_out  <= rd_in;
      end
      default: begin
        npc_out <= npc_out;
        rd1_out <= rd1_out;
        rd2_out <= rd2_out;
        imm_out <= imm_out;
        rt_out  <= rt_out;
        rd_out  <= rd_out;
      end
    endcase
  end

`ifdef IDEX_FORWARD_EN
  // Source register for the forwarding unit. A bubble clears it so that the
  // forwarding unit never matches on a squashed slot.
  always_ff @(posedge clk) begin
    unique case (action)
      ACT_RESET, ACT_FLUSH, ACT_BUBBLE: rs_out <= '0;
      ACT_LOAD:                         rs_out <= rs_in;
      default:                          rs_out <= rs_out;
    endcase
  end
`endif

  // Count inserted bubbles. A flush in the same cycle as a hazard is one
  // action, so it adds one count.
  always_ff @(posedge clk) begin
    unique case (action)
      ACT_RESET:              bubble_cnt <= '0;
      ACT_FLUSH, ACT_BUBBLE:  bubble_cnt <= bubble_cnt_inc;
      default:                bubble_cnt <= bubble_cnt;
    endcase
  end

endmodule

// File: tb/tb_id_ex_latch.sv
// Self-checking bench for id_ex_latch: directed scenarios plus randomized
// traffic, compared each cycle against a behavioural model of the latch.
module tb_id_ex_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ex_in;
  logic [2:0]  m_in;
  logic [1:0]  wb_in;
  logic [31:0] npc_in, rd1_in, rd2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic        flush, hold;
  logic [3:0]  ex_out;
  logic [2:0]  m_out;
  logic [1:0]  wb_out;
  logic [31:0] npc_out, rd1_out, rd2_out, imm_out;
  logic [4:0]  rt_out, rd_out;
`ifdef IDEX_FORWARD_EN
  logic [4:0]  rs_out;
`endif
  logic        valid_out, stall_out;
  logic [15:0] bubble_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_latch dut (
    .clk(clk), .rst_n(rst_n),
    .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
    .npc_in(npc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .flush(flush), .hold(hold),
    .ex_out(ex_out), .m_out(m_out), .wb_out(wb_out),
    .npc_out(npc_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .rt_out(rt_out), .rd_out(rd_out),
`ifdef IDEX_FORWARD_EN
    .rs_out(rs_out),
`endif
    .valid_out(valid_out), .stall_out(stall_out), .bubble_cnt(bubble_cnt)
  );

  // Reference model: the EX slot as the pipeline sees it.
  typedef struct {
    logic [3:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] npc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        valid;
    int          bubbles;   // unbounded count; the DUT shows it clipped
  } slot_t;

  slot_t exp_slot;
  logic  exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // The EX slot holds a load (MemRead) whose destination rt is read by the
  // instruction in decode.
  function automatic logic model_stall();
    return exp_slot.valid && exp_slot.m[1] &&
           (exp_slot.rt == rs_in || exp_slot.rt == rt_in) && !flush;
  endfunction

  task automatic model_clear();
    exp_slot = '{ex: 0, m: 0, wb: 0, npc: 0, rd1: 0, rd2: 0, imm: 0,
                 rs: 0, rt: 0, rd: 0, valid: 0, bubbles: 0};
  endtask

  task automatic model_edge(input logic stall_now);
    if (!rst_n) begin
      model_clear();
    end else if (flush || (!hold && stall_now)) begin
      exp_slot.ex = 0; exp_slot.m = 0; exp_slot.wb = 0;
      exp_slot.rs = 0; exp_slot.valid = 0;
      exp_slot.bubbles++;
    end else if (!hold) begin
      exp_slot.ex = ex_in;   exp_slot.m = m_in;     exp_slot.wb = wb_in;
      exp_slot.npc = npc_in; exp_slot.rd1 = rd1_in; exp_slot.rd2 = rd2_in;
      exp_slot.imm = imm_in; exp_slot.rs = rs_in;   exp_slot.rt = rt_in;
      exp_slot.rd = rd_in;   exp_slot.valid = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int sat;
    sat = (exp_slot.bubbles > 65535) ? 65535 : exp_slot.bubbles;
    check("ex_out",  ex_out,  exp_slot.ex);
    check("m_out",   m_out,   exp_slot.m);
    check("wb_out",  wb_out,  exp_slot.wb);
    check("valid",   valid_out, exp_slot.valid);
    check("bubbles", bubble_cnt, sat[15:0]);
    // Datapath registers hold real content only while the slot is valid.
    if (exp_slot.valid || !rst_n) begin
      check("npc_out", npc_out, exp_slot.npc);
      check("rd1_out", rd1_out, exp_slot.rd1);
      check("rd2_out", rd2_out, exp_slot.rd2);
      check("imm_out", imm_out, exp_slot.imm);
      check("rt_out",  rt_out,  exp_slot.rt);
      check("rd_out",  rd_out,  exp_slot.rd);
    end
`ifdef IDEX_FORWARD_EN
    check("rs_out", rs_out, exp_slot.rs);
`endif
  endtask

  // Inputs are applied at the negedge. Check stall, clock one edge, then check
  // the registered outputs at the next negedge.
  task automatic cycle();
    #1;
    exp_stall = model_stall();
    check("stall", stall_out, exp_stall);
    @(posedge clk);
    model_edge(exp_stall);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_inputs();
    ex_in  = 4'($urandom);   m_in   = 3'($urandom);  wb_in = 2'($urandom);
    npc_in = $urandom;       rd1_in = $urandom;      rd2_in = $urandom;
    imm_in = $urandom;       rs_in  = 5'($urandom);  rt_in  = 5'($urandom);
    rd_in  = 5'($urandom);
  endtask

  task automatic apply_lw(input logic [4:0] rt);
    rand_inputs();
    ex_in = 4'b0001; m_in = 3'b010; wb_in = 2'b11; rt_in = rt;
    flush = 0; hold = 0;
    cycle();
  endtask

  int cnt_before;

  initial begin
    model_clear();
    rand_inputs();
    flush = 1'($urandom); hold = 1'($urandom); rst_n = 1'b0;
    @(negedge clk);

    // Reset for two cycles while the inputs are random.
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); flush = 1'($urandom); hold = 1'($urandom);
      @(posedge clk); model_edge(1'b0); @(negedge clk);
      check_outputs();
      check("rst_stall", stall_out, 1'b0);
    end
    rst_n = 1'b1;

    // R-type load.
    rand_inputs(); flush = 0; hold = 0;
    ex_in = 4'b1100; m_in = 3'b000; wb_in = 2'b10; rd1_in = 32'h0000_0005;
    cycle();
    check("rtype_ex",  ex_out, 4'b1100);
    check("rtype_wb",  wb_out, 2'b10);
    check("rtype_rd1", rd1_out, 32'h5);
    check("rtype_vld", valid_out, 1'b1);

    // Load-use: LW writing r8, followed by an instruction that reads r8.
    apply_lw(5'd8);
    rand_inputs(); m_in = 3'b000; rs_in = 5'd8; flush = 0; hold = 0;
    #1 check("lu_stall", stall_out, 1'b1);
    cycle();
    check("lu_bub_ex",  ex_out, 4'b0);
    check("lu_bub_m",   m_out,  3'b0);
    check("lu_bub_vld", valid_out, 1'b0);
    check("lu_bub_cnt", bubble_cnt, 16'd1);
    #1 check("lu_release", stall_out, 1'b0);
    cycle();
    check("lu_reload", valid_out, 1'b1);

    // Flush and hazard in the same cycle count as one bubble.
    apply_lw(5'd8);
    cnt_before = int'(bubble_cnt);
    rand_inputs(); rs_in = 5'd8; flush = 1;
    cycle();
    check("fh_one_bubble", bubble_cnt, 32'(cnt_before + 1));
    flush = 0;

    // Reset in the middle of a stall clears the hazard.
    apply_lw(5'd8);
    rand_inputs(); rs_in = 5'd8;
    #1 check("mid_stall", stall_out, 1'b1);
    rst_n = 0;
    @(posedge clk); model_edge(1'b0); @(negedge clk);
    rst_n = 1;
    #1 check("rst_clr_stall", stall_out, 1'b0);
    check_outputs();

    // Hold for three cycles while the inputs change and the hazard is present.
    apply_lw(5'd8);
    cnt_before = int'(bubble_cnt);
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); rs_in = 5'd8; hold = 1; flush = 0;
      cycle();
      check("hold_stall", stall_out, 1'b1);
      check("hold_cnt", bubble_cnt, 32'(cnt_before));
      check("hold_m", m_out, 3'b010);
    end
    hold = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      cycle();
    end
    rst_n = 1; flush = 0; hold = 0;

    // Saturation: flush until the counter reaches FFFE, then three more.
    for (int i = 0; i < 70000 && exp_slot.bubbles < 65534; i++) begin
      rand_inputs(); flush = 1;
      cycle();
    end
    check("sat_pre", bubble_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); flush = 1;
      cycle();
      check("sat", bubble_cnt, 16'hFFFF);
    end
    flush = 0;

    // Random traffic after saturation.
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      flush = ($urandom_range(0, 4) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
